// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: stage indices, stall/flush vector and FSM state encoding.
package pipe_pkg;

  localparam int unsigned NStages = 5;
  localparam int unsigned PC      = 0;
  localparam int unsigned IFID    = 1;
  localparam int unsigned IDEX    = 2;
  localparam int unsigned EXMEM   = 3;
  localparam int unsigned MEMWB   = 4;

  typedef logic [NStages-1:0] stage_vec_t;

  // Encoding is {mem_p, ex_p}, so the pending flags read straight off the state.
  typedef enum logic [1:0] {
    StRun      = 2'b00,
    StWaitEx   = 2'b01,
    StWaitMem  = 2'b10,
    StWaitBoth = 2'b11
  } state_e;

  // Stall mask covering the PC and every stage register up to and including 'last'.
  function automatic stage_vec_t stages_upto(int unsigned last);
    stage_vec_t v;
    for (int unsigned i = 0; i < NStages; i++) begin
      v[i] = (i <= last);
    end
    return v;
  endfunction

endpackage

// File: rtl/hazard_lu.sv
// Load-use hazard detect: the ID instruction needs a register a load in EX has not produced yet.
module hazard_lu (
  input  logic       ex_load_ea_i,
  input  logic       ex_wb_ena_i,
  input  logic [4:0] ex_wb_addr_i,
  input  logic [4:0] id_rs_addr_i,
  input  logic [4:0] id_rt_addr_i,
  input  logic       id_rs_read_i,
  input  logic       id_rt_read_i,
  output logic       lu_o
);

  logic rs_hit, rt_hit;

  always_comb begin
    rs_hit = id_rs_read_i && (id_rs_addr_i == ex_wb_addr_i);
    rt_hit = id_rt_read_i && (id_rt_addr_i == ex_wb_addr_i);
    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    lu_o   = ex_load_ea_i && ex_wb_ena_i && (ex_wb_addr_i != 5'd0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush generation for the five-stage pipeline, with multi-cycle EX/MEM
// wait tracking, a saturating stall-cycle counter and a sticky wait watchdog.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_rs_read,
  input  logic        id_rt_read,
  input  logic        id_branch_taken,
  input  logic        ex_load_ea,
  input  logic        ex_wb_ena,
  input  logic [4:0]  ex_wb_addr,
  input  logic        ex_multi_req,
  input  logic        ex_multi_done,
  input  logic        mem_req,
  input  logic        mem_ack,
  output stage_vec_t  stall,
  output stage_vec_t  flush,
  output logic [31:0] stall_cycles,
  output logic        timeout_err
);

  state_e      state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        timeout_err_q, timeout_err_d;

  logic ex_p, mem_p, ex_p_d, mem_p_d;
  logic mw, xw, lu;

  hazard_lu u_hazard_lu (
    .ex_load_ea_i (ex_load_ea),
    .ex_wb_ena_i  (ex_wb_ena),
    .ex_wb_addr_i (ex_wb_addr),
    .id_rs_addr_i (id_rs_addr),
    .id_rt_addr_i (id_rt_addr),
    .id_rs_read_i (id_rs_read),
    .id_rt_read_i (id_rt_read),
    .lu_o         (lu)
  );

  // Mealy outputs: a request stalls on the very edge it arrives, a done releases at once.
  always_comb begin
    ex_p  = (state_q == StWaitEx) || (state_q == StWaitBoth);
    mem_p = (state_q == StWaitMem) || (state_q == StWaitBoth);
    mw    = (mem_p || mem_req) && !mem_ack;
    xw    = (ex_p || ex_multi_req) && !ex_multi_done;

    stall = '0;
    flush = '0;
    if (mw) begin
      stall        = stages_upto(EXMEM);
      flush[MEMWB] = 1'b1;
    end else if (xw) begin
      stall        = stages_upto(IDEX);
      flush[EXMEM] = 1'b1;
    end else if (lu) begin
      stall       = stages_upto(IFID);
      flush[IDEX] = 1'b1;
    end else if (id_branch_taken) begin
      // Only reachable with ID unstalled; a held branch re-asserts after the stall.
      flush[IFID] = 1'b1;
    end
  end

  always_comb begin
    ex_p_d  = ex_multi_done ? 1'b0 : (ex_multi_req ? 1'b1 : ex_p);
    mem_p_d = mem_ack ? 1'b0 : (mem_req ? 1'b1 : mem_p);
    state_d = state_e'({mem_p_d, ex_p_d});

    wait_cnt_d = '0;
    if (state_q != StRun) begin
      wait_cnt_d = (wait_cnt_q >= TIMEOUT) ? wait_cnt_q : wait_cnt_q + 32'd1;
    end
    timeout_err_d = timeout_err_q || (wait_cnt_d >= TIMEOUT);

    stall_cycles_d = stall_cycles_q;
    if (stall[PC] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline control for the five-stage MIPS core. Consumes hazard and busy indications from ID, EX and MEM, and drives the per-stage `stall`/`flush` vectors that every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register obey. Tracks outstanding multi-cycle EX operations and memory transactions in a small FSM. Also keeps a stall-cycle counter and a watchdog.

## Interface
- `TIMEOUT`, default 1024: wait cycles in a non-RUN state before `timeout_err` sets.
- `clk  in  1`: clock.
- `rst  in  1`: reset, synchronous, active-high.
- `id_rs_addr  in  5`: rs index of the instruction in ID.
- `id_rt_addr  in  5`: rt index of the instruction in ID.
- `id_rs_read  in  1`: ID instruction reads rs.
- `id_rt_read  in  1`: ID instruction reads rt.
- `id_branch_taken  in  1`: branch or jump resolved taken in ID.
- `ex_load_ea  in  1`: instruction in EX is a load.
- `ex_wb_ena  in  1`: EX instruction writes the register file.
- `ex_wb_addr  in  5`: EX destination register.
- `ex_multi_req  in  1`: one-cycle pulse, a multi-cycle EX operation (mult/div) starts.
- `ex_multi_done  in  1`: one-cycle pulse, the multi-cycle op result is ready.
- `mem_req  in  1`: one-cycle pulse, MEM issues a bus transaction.
- `mem_ack  in  1`: one-cycle pulse, bus transaction complete.
- `stall  out  5`: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB. Register holds while its bit is 1.
- `flush  out  5`: same bit map. Register loads a zero bubble.
- `stall_cycles  out  32`: saturating count of cycles with `stall[0]`=1.
- `timeout_err  out  1`: sticky watchdog flag.

## Operation
- FSM states: RUN, WAIT_EX, WAIT_MEM, WAIT_BOTH. Pending flags are `ex_p` (multi op outstanding) and `mem_p` (bus transaction outstanding).
  - `ex_p` sets on `ex_multi_req` && !`ex_multi_done`. It clears on `ex_multi_done`.
  - `mem_p` sets on `mem_req` && !`mem_ack`. It clears on `mem_ack`.
  - State = {mem_p, ex_p}: 00 RUN, 01 WAIT_EX, 10 WAIT_MEM, 11 WAIT_BOTH.
- Effective conditions (Mealy; current cycle):
  - `mw` = (mem_p || mem_req) && !mem_ack.
  - `xw` = (ex_p || ex_multi_req) && !ex_multi_done.
- Priority of outputs, highest first:
  1. `mw`: stall=5'b01111, flush=5'b10000.
  2. `xw`: stall=5'b00111, flush=5'b01000.
  3. Load-use (`lu`): condition is ex_load_ea && ex_wb_ena && ex_wb_addr!=0 && ((id_rs_read && id_rs_addr==ex_wb_addr) || (id_rt_read && id_rt_addr==ex_wb_addr)). Output stall=5'b00011, flush=5'b00100.
  4. `id_branch_taken`: stall=0, flush=5'b00010.
  5. Otherwise stall=0, flush=0.
- A taken branch is ignored while ID is stalled (cases 1–3). ID holds the branch, so it re-asserts once the stall releases.
- `stall_cycles` increments when `stall[0]`=1 and stops at 32'hFFFFFFFF.
- `timeout_err`:
  - A wait counter increments each cycle the state is not RUN and clears in RUN.
  - When the counter reaches `TIMEOUT`, `timeout_err` sets. It stays set until `rst`.
  - The FSM is not forced out of the wait state.

## Timing
- Reset (on `rst` at a clock edge, including mid-wait): state RUN, `ex_p`=`mem_p`=0, counters 0, `timeout_err`=0.
  - With all inputs low after reset, stall=0 and flush=0.
- `stall`/`flush` are combinational from state plus current inputs. They apply on the same edge as the triggering pulse, so there is zero-latency stall.
- Request and done in the same cycle: no stall, state stays RUN.
- Load-use costs exactly one bubble cycle. The next cycle the load is in MEM and `lu` is false.
- Release: in the cycle `mem_ack` (or `ex_multi_done`) arrives, that wait's stall drops. The state updates on the following edge.
- `mem_req` while WAIT_EX → WAIT_BOTH. MEM stall dominates until ack, then the EX stall continues if `ex_p` is still set.
- Done pulse while WAIT_BOTH: only the matching flag clears.
- Spurious `ex_multi_done`/`mem_ack` in RUN: ignored.

## Structure
- Shared package `pipe_pkg`:
  - stage index constants PC=0, IFID=1, IDEX=2, EXMEM=3, MEMWB=4;
  - 5-bit stall/flush vector typedef;
  - FSM state typedef.
- One sub-module `hazard_lu`: purely combinational load-use comparator producing `lu`. Everything else is in `pipe_ctrl`.

## Test plan
- Reset mid-WAIT_MEM (mem_req, no ack, then rst) → next cycle stall=0, flush=0, stall_cycles=0, state RUN.
- EX load to r5, ID reads rt=5 → one cycle stall=00011, flush=00100, then 0. Same with ex_wb_addr=0 → no stall.
- ex_multi_req pulse, ex_multi_done 6 cycles later → stall=00111 / flush=01000 for exactly 6 cycles, then 0. stall_cycles=6.
- mem_req during WAIT_EX, mem_ack after 3 cycles, multi done 2 cycles later → 3 cycles stall=01111, then 2 cycles stall=00111, then 0.
- id_branch_taken with lu active → flush=00100 only. Next cycle, branch alone → flush=00010.
- TIMEOUT=8, mem_req with no ack → timeout_err=1 after 8 wait cycles and stays 1 after mem_ack until rst.
